bcd_to_binary_seq: RTL and testbench

//   Sequential packed-BCD to unsigned-binary converter (reverse double-dabble).

---
 rtl/bcd_pkg.sv | 39 +++
 rtl/bcd_digit_corr.sv | 16 +
 rtl/bcd_to_binary_seq.sv | 162 ++++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_e          : FSM encoding (ST_IDLE / ST_SHIFT / ST_DONE)
//   BCD_CORR_THRESH  : digit value at or above which the -3 correction applies
//   BCD_CORR_SUB     : correction amount
//   BCD_MAX_DIGIT    : largest legal BCD digit (used by the optional error check)
//   clog2 / pow10    : elaboration-time helpers for the BIN_W sizing check
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
  localparam logic [3:0] BCD_CORR_SUB    = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned p;
    r = 0;
    p = 64'd1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-digit correction for reverse double-dabble: after each right shift a
// digit that reads 8 or more carried a "ten" into the lower neighbour's
// weight-5 position, so 3 is removed to restore a valid BCD digit.
//   d_i : shifted BCD digit
//   d_o : corrected BCD digit
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Never underflows: subtraction only happens when d_i >= 8.
  assign d_o = (d_i >= BCD_CORR_THRESH) ? (d_i - BCD_CORR_SUB) : d_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned-binary converter (reverse double-dabble),
// one shift per clock, valid/ready on both sides.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : request present on bcd_in
//   in_ready   : converter idle, request will be captured
//   bcd_in     : packed BCD, digit 0 (units) in [3:0]
//   out_valid  : result present on bin_out (held until out_ready)
//   out_ready  : consumer takes the result
//   bin_out    : converted value, 0 whenever out_valid is low
//   err        : invalid-digit flag, only when BCD_ERR_EN is defined
// Optional feature macro: BCD_ERR_EN (digit > 9 at capture -> immediate
// DONE with bin_out=0, err=1).
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        bin_out
`ifdef BCD_ERR_EN
  ,
  output logic                    err
`endif
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = clog2(64'(BIN_W) + 64'd1);

  generate
    if (NUM_DIGITS < 1) begin : g_bad_digits
      $error("bcd_to_binary_seq: NUM_DIGITS must be >= 1");
    end
    if (BIN_W < clog2(pow10(NUM_DIGITS))) begin : g_bad_width
      $error("bcd_to_binary_seq: BIN_W too narrow for NUM_DIGITS");
    end
  endgenerate

  state_e                       state_q, state_d;
  logic [BCD_W-1:0]             bcd_q, bcd_d;
  logic [BIN_W-1:0]             bin_q, bin_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BCD_W+BIN_W-1:0]       cat_sh;
  logic [NUM_DIGITS-1:0][3:0]   dig_sh;
  logic [NUM_DIGITS-1:0][3:0]   dig_corr;
  logic                         last_shift;

  // One step: shift the {bcd,bin} pair right, then correct every digit.
  assign cat_sh     = {bcd_q, bin_q} >> 1;
  assign dig_sh     = cat_sh[BCD_W+BIN_W-1:BIN_W];
  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_corr
      bcd_digit_corr u_corr (
        .d_i (dig_sh[g]),
        .d_o (dig_corr[g])
      );
    end
  endgenerate

`ifdef BCD_ERR_EN
  logic err_q, err_d, bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_in[4*i +: 4] > BCD_MAX_DIGIT) bad_digit = 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (in_valid) begin
`ifdef BCD_ERR_EN
          state_d = bad_digit ? ST_DONE : ST_SHIFT;
`else
          state_d = ST_SHIFT;
`endif
        end
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE:  if (out_ready)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    cnt_d = cnt_q;
`ifdef BCD_ERR_EN
    err_d = err_q;
`endif
    case (state_q)
      ST_IDLE:
        if (in_valid) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = '0;
`ifdef BCD_ERR_EN
          err_d = bad_digit;
`endif
        end
      ST_SHIFT: begin
        bcd_d = dig_corr;
        bin_d = cat_sh[BIN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
`ifdef BCD_ERR_EN
        if (out_ready) err_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
`ifdef BCD_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
      cnt_q <= cnt_d;
`ifdef BCD_ERR_EN
      err_q <= err_d;
`endif
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    bin_out   = out_valid ? bin_q : '0;
`ifdef BCD_ERR_EN
    err       = out_valid & err_q;
`endif
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
module tb_bcd_to_binary_seq;

  typedef struct {
    int   bin;
    logic err;
  } exp_t;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  bcd_in;
  logic [6:0]  bin_out;
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [15:0] w_bcd_in;
  logic [13:0] w_bin_out;
`ifdef BCD_ERR_EN
  logic        err, w_err;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   hs_cyc = 0;
  exp_t exp_q[$];
  exp_t wexp_q[$];

  bcd_to_binary_seq #(.NUM_DIGITS(2), .BIN_W(7)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out)
`ifdef BCD_ERR_EN
    , .err(err)
`endif
  );

  bcd_to_binary_seq #(.NUM_DIGITS(4), .BIN_W(14)) u_dut_wide (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .bcd_in(w_bcd_in), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .bin_out(w_bin_out)
`ifdef BCD_ERR_EN
    , .err(w_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: weighted decimal sum of the digits.
  function automatic exp_t model(input logic [15:0] b, input int nd);
    exp_t e;
    int   p;
    logic [3:0] d;
    e.bin = 0;
    e.err = 1'b0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      d = b[4*i +: 4];
      if (d > 4'd9) e.err = 1'b1;
      e.bin += int'(d) * p;
      p *= 10;
    end
`ifdef BCD_ERR_EN
    if (e.err) e.bin = 0;
`endif
    return e;
  endfunction

  // Present a request and complete its handshake; returns #1 after the edge.
  task automatic drive_req(input logic [7:0] b);
    @(negedge clk);
    bcd_in   = b;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready: in_ready=%b expected 1 (bcd=%h)", in_ready, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hs_cyc   = cyc;
    exp_q.push_back(model({8'h00, b}, 2));
  endtask

  // Wait for the result, check latency/value, hold with out_ready=0, then take it.
  task automatic wait_result(input string nm, input int exp_cycle, input int hold);
    exp_t e;
    int   guard;
    guard = 0;
    e = exp_q.pop_front();
    while (out_valid !== 1'b1 && guard < 64) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%b expected 1", nm, out_valid);
      return;
    end
    checks++;
    if (cyc - hs_cyc + 1 != exp_cycle) begin
      errors++;
      $display("FAIL %s latency: cycle %0d expected %0d", nm, cyc - hs_cyc + 1, exp_cycle);
    end
    checks++;
    if (bin_out !== 7'(e.bin)) begin
      errors++;
      $display("FAIL %s value: bin_out=%0d expected %0d", nm, bin_out, e.bin);
    end
`ifdef BCD_ERR_EN
    checks++;
    if (err !== e.err) begin
      errors++;
      $display("FAIL %s err: err=%b expected %b", nm, err, e.err);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || bin_out !== 7'(e.bin)) begin
        errors++;
        $display("FAIL %s hold%0d: out_valid=%b bin_out=%0d expected 1/%0d",
                 nm, i, out_valid, bin_out, e.bin);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 7'd0 ||
        w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_bin_out !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b bin_out=%0d w=%b/%b/%0d expected 1/0/0",
               in_ready, out_valid, bin_out, w_in_ready, w_out_valid, w_bin_out);
    end
`ifdef BCD_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b expected 0", err);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    // out_ready with nothing pending must be harmless
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_out_ready: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_convert();
    drive_req(8'h99); wait_result("conv99", 8, 0);
    drive_req(8'h00); wait_result("conv00", 8, 0);
    drive_req(8'h42); wait_result("conv42", 8, 0);
  endtask

  task automatic test_backpressure();
    drive_req(8'h57); wait_result("hold57", 8, 5);
  endtask

  task automatic test_ignore_busy();
    drive_req(8'h42);
    @(negedge clk);
    bcd_in   = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready%0d: in_ready=%b expected 0", i, in_ready);
      end
    end
    in_valid = 1'b0;
    wait_result("ignore42", 8, 0);
    // the ignored request must not produce a second result
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_extra: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    exp_t dropped;
    drive_req(8'h57);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== 7'd0) begin
      errors++;
      $display("FAIL midreset: out_valid=%b in_ready=%b bin_out=%0d expected 0/1/0",
               out_valid, in_ready, bin_out);
    end
    dropped = exp_q.pop_front();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_partial: out_valid=%b expected 0 (dropped %0d)", out_valid, dropped.bin);
    end
    drive_req(8'h25); wait_result("after_rst25", 8, 0);
  endtask

  task automatic test_back_to_back();
    int v;
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 99);
      drive_req({4'(v / 10), 4'(v % 10)});
      wait_result("b2b", 8, i % 2);
    end
  endtask

`ifdef BCD_ERR_EN
  task automatic test_err();
    drive_req(8'h3A); wait_result("err3A", 1, 2);
    drive_req(8'hF0); wait_result("errF0", 1, 0);
    drive_req(8'h19); wait_result("ok19", 8, 0);
  endtask
`endif

  task automatic test_wide();
    logic [15:0] vals [3];
    exp_t e;
    int   hs, guard;
    vals[0] = 16'h9999;
    vals[1] = 16'h1234;
    vals[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w_bcd_in   = vals[i];
      w_in_valid = 1'b1;
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      hs = cyc;
      wexp_q.push_back(model(vals[i], 4));
      guard = 0;
      while (w_out_valid !== 1'b1 && guard < 64) begin
        @(posedge clk);
        #1;
        guard++;
      end
      e = wexp_q.pop_front();
      checks++;
      if (w_out_valid !== 1'b1 || cyc - hs + 1 != 15) begin
        errors++;
        $display("FAIL wide_latency: out_valid=%b cycle %0d expected 1 at 15",
                 w_out_valid, cyc - hs + 1);
      end
      checks++;
      if (w_bin_out !== 14'(e.bin)) begin
        errors++;
        $display("FAIL wide_value: bin_out=%0d expected %0d", w_bin_out, e.bin);
      end
      @(negedge clk);
      w_out_ready = 1'b1;
      @(posedge clk);
      #1;
      w_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    bcd_in      = 8'h00;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
    w_bcd_in    = 16'h0000;
    test_reset();
    test_convert();
    test_backpressure();
    test_ignore_busy();
    test_reset_midflight();
    test_back_to_back();
`ifdef BCD_ERR_EN
    test_err();
`endif
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
